traffic_interval_timer: RTL

Timing and sensor datapath that sits directly upstream of the traffic-light controller FSM. It produces the four transition conditions the controller consumes: `not_r`, `c_and_l`, `en_s` and `l_or_notc`. It takes the interval select `s_IC` / `en_IC` back from the controller, times each light phase and conditions the east-approach car sensor. Controller plus this block form the complete intersection core.

---
 rtl/traffic_interval_timer_if.sv | 33 +++
 rtl/traffic_interval_timer.sv | 102 ++++++++++
 2 files changed

// File: rtl/traffic_interval_timer_if.sv
// rtl/traffic_interval_timer_if.sv - controller-to-timer handshake: interval select in, transition conditions out
interface traffic_interval_timer_if #(
  parameter int unsigned W = 8
);
  logic [1:0]   s_IC;
  logic         en_IC;
  logic         not_r;
  logic         c_and_l;
  logic         en_s;
  logic         l_or_notc;
  logic [W-1:0] elapsed;

  // master is the traffic-light controller, slave is the interval timer
  modport master (
    output s_IC,
    output en_IC,
    input  not_r,
    input  c_and_l,
    input  en_s,
    input  l_or_notc,
    input  elapsed
  );

  modport slave (
    input  s_IC,
    input  en_IC,
    output not_r,
    output c_and_l,
    output en_s,
    output l_or_notc,
    output elapsed
  );
endinterface

// File: rtl/traffic_interval_timer.sv
// rtl/traffic_interval_timer.sv - per-phase dwell timer and east car-sensor conditioning for the light controller
module traffic_interval_timer #(
  parameter int unsigned W     = 8,
  parameter int unsigned T_YEL = 3,
  parameter int unsigned T_RR  = 2,
  parameter int unsigned T_NG  = 20,
  parameter int unsigned T_EG  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   car_e,
  traffic_interval_timer_if.slave tif
);

  localparam logic [1:0] PH_YEL = 2'b00;
  localparam logic [1:0] PH_RR  = 2'b01;
  localparam logic [1:0] PH_NG  = 2'b10;
  localparam logic [1:0] PH_EG  = 2'b11;

  // completion fires on the last cycle of the dwell, so compare against T-1
  localparam logic [W-1:0] LIM_YEL = W'(T_YEL - 1);
  localparam logic [W-1:0] LIM_RR  = W'(T_RR - 1);
  localparam logic [W-1:0] LIM_NG  = W'(T_NG - 1);
  localparam logic [W-1:0] LIM_EG  = W'(T_EG - 1);
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic         sync_q1;
  logic         car_s;
  logic         car_pend;
  logic [1:0]   prev_ic;
  logic [W-1:0] elapsed_q;

  logic         new_phase;
  logic         eg_entry;
  logic [W-1:0] eff;
  logic [W-1:0] eff_inc;
  logic [W-1:0] elapsed_d;
  logic [W-1:0] limit;
  logic         done;

  always_comb begin
    new_phase = (tif.s_IC != prev_ic);
    eg_entry  = new_phase && (tif.s_IC == PH_EG);
    eff       = new_phase ? '0 : elapsed_q;
    eff_inc   = (eff == CNT_MAX) ? eff : eff + CNT_ONE;
    elapsed_d = tif.en_IC ? eff_inc : eff;
  end

  always_comb begin
    limit = LIM_RR;
    case (tif.s_IC)
      PH_YEL:  limit = LIM_YEL;
      PH_RR:   limit = LIM_RR;
      PH_NG:   limit = LIM_NG;
      PH_EG:   limit = LIM_EG;
      default: limit = LIM_RR;
    endcase
    done = (eff >= limit);
  end

  always_comb begin
    tif.en_s      = (tif.s_IC == PH_YEL) && done;
    tif.not_r     = (tif.s_IC == PH_RR)  && done;
    tif.c_and_l   = (tif.s_IC == PH_NG)  && done && car_pend;
    tif.l_or_notc = (tif.s_IC == PH_EG)  && (done || !car_s);
    tif.elapsed   = eff;
  end

  // car_e is asynchronous to clk; two flops before anything looks at it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      car_s   <= 1'b0;
    end else begin
      sync_q1 <= car_e;
      car_s   <= sync_q1;
    end
  end

  // entry into east green services the pending car, even if the sensor is still high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_pend <= 1'b0;
    end else if (eg_entry) begin
      car_pend <= 1'b0;
    end else if (car_s) begin
      car_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ic   <= PH_RR;
      elapsed_q <= '0;
    end else begin
      prev_ic   <= tif.s_IC;
      elapsed_q <= elapsed_d;
    end
  end

endmodule
